// File: rtl/gen_window_sequencer_if.sv
// Beat bus from the window sequencer to the four-lane multiplier stage.
// The master drives frow/check_wcol_out/out_last under out_valid, and the slave answers with out_ready.
interface gen_window_sequencer_if;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] frow;
    logic [1:0]  check_wcol_out;
    logic        out_last;

    modport master (
        output out_valid,
        output frow,
        output check_wcol_out,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  frow,
        input  check_wcol_out,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/gen_window_sequencer.sv
// Row/column sweep sequencer for the generate_window multiply stage.
// It walks rows 0..cfg_rows-1, and within each row steps sel through 0..cfg_sel, issuing one beat per step.
module gen_window_sequencer #(
    parameter int unsigned ROW_W = 16
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 start,
    input  logic [ROW_W-1:0]     num_rows,
    input  logic [1:0]           last_sel,
    gen_window_sequencer_if.master out_if,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [1:0]       sel_q, sel_d;
    logic [ROW_W-1:0] cfg_rows_q, cfg_rows_d;
    logic [1:0]       cfg_sel_q, cfg_sel_d;
    logic             is_last;

    // The last beat is decoded from registered counters only, so out_ready has no combinational path to any output.
    assign is_last = (row_q == (cfg_rows_q - ROW_W'(1))) && (sel_q == cfg_sel_q);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= IDLE;
            row_q      <= '0;
            sel_q      <= '0;
            cfg_rows_q <= '0;
            cfg_sel_q  <= '0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            sel_q      <= sel_d;
            cfg_rows_q <= cfg_rows_d;
            cfg_sel_q  <= cfg_sel_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        sel_d      = sel_q;
        cfg_rows_d = cfg_rows_q;
        cfg_sel_d  = cfg_sel_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (num_rows != '0) begin
                        cfg_rows_d = num_rows;
                        cfg_sel_d  = (last_sel == 2'd3) ? 2'd2 : last_sel;
                        row_d      = '0;
                        sel_d      = '0;
                        state_d    = ISSUE;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            ISSUE: begin
                if (out_if.out_ready) begin
                    if (is_last) begin
                        state_d = DONE;
                    end else if (sel_q != cfg_sel_q) begin
                        sel_d = sel_q + 2'd1;
                    end else begin
                        sel_d = '0;
                        row_d = row_q + ROW_W'(1);
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_if.out_valid      = 1'b0;
        out_if.frow           = '0;
        out_if.check_wcol_out = '0;
        out_if.out_last       = 1'b0;
        busy                  = 1'b0;
        done                  = 1'b0;
        unique case (state_q)
            ISSUE: begin
                out_if.out_valid      = 1'b1;
                out_if.frow           = 32'(row_q);
                out_if.check_wcol_out = sel_q;
                out_if.out_last       = is_last;
                busy                  = 1'b1;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_gen_window_sequencer.sv
// Directed bench for gen_window_sequencer.
// Expected beats are queued when a sweep starts and are popped as the DUT transfers them.
module tb_gen_window_sequencer;

    localparam int unsigned ROW_W = 16;

    logic             Clk = 1'b0;
    logic             Rst;
    logic             start;
    logic [ROW_W-1:0] num_rows;
    logic [1:0]       last_sel;
    logic             busy;
    logic             done;

    gen_window_sequencer_if bus ();

    gen_window_sequencer #(.ROW_W(ROW_W)) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .start    (start),
        .num_rows (num_rows),
        .last_sel (last_sel),
        .out_if   (bus.master),
        .busy     (busy),
        .done     (done)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [31:0] frow;
        logic [1:0]  sel;
        logic        last;
    } beat_t;

    beat_t sb[$];
    int    checks   = 0;
    int    failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Outputs are sampled and inputs are driven 1 time unit after each rising edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic push_sweep(input int unsigned rows, input int unsigned lsel);
        int unsigned s;
        beat_t b;
        s = (lsel == 3) ? 2 : lsel;
        for (int unsigned r = 0; r < rows; r++) begin
            for (int unsigned c = 0; c <= s; c++) begin
                b.frow = 32'(r);
                b.sel  = 2'(c);
                b.last = (r == rows - 1) && (c == s);
                sb.push_back(b);
            end
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, 32'(bus.out_valid), 0);
        chk({tag, "_frow"},  bus.frow, 0);
        chk({tag, "_sel"},   32'(bus.check_wcol_out), 0);
        chk({tag, "_last"},  32'(bus.out_last), 0);
        chk({tag, "_busy"},  32'(busy), 0);
        chk({tag, "_done"},  32'(done), 0);
    endtask

    task automatic do_start(input int unsigned rows, input int unsigned lsel);
        start    = 1'b1;
        num_rows = ROW_W'(rows);
        last_sel = 2'(lsel);
        tick();
        start = 1'b0;
    endtask

    // Runs the sweep and checks every cycle against the scoreboard head.
    // It returns when done is seen, or early after max_xfers transfers.
    task automatic run(input string tag, input logic [31:0] pat, input int pat_len,
                       input int max_xfers, input int budget);
        int  xfers = 0;
        bit  exp_valid;
        beat_t h;
        for (int cyc = 0; cyc < budget; cyc++) begin
            bus.out_ready = (cyc < pat_len) ? pat[cyc] : 1'b1;
            exp_valid = (sb.size() != 0);
            chk({tag, "_valid"}, 32'(bus.out_valid), 32'(exp_valid));
            chk({tag, "_busy"},  32'(busy), 32'(exp_valid));
            if (exp_valid) begin
                h = sb[0];
                chk({tag, "_frow"}, bus.frow, h.frow);
                chk({tag, "_sel"},  32'(bus.check_wcol_out), 32'(h.sel));
                chk({tag, "_last"}, 32'(bus.out_last), 32'(h.last));
                chk({tag, "_done_early"}, 32'(done), 0);
                if (bus.out_ready) begin
                    void'(sb.pop_front());
                    xfers++;
                    if (xfers == max_xfers) begin
                        tick();
                        return;
                    end
                end
            end else begin
                chk({tag, "_done"}, 32'(done), 1);
                chk({tag, "_last_in_done"}, 32'(bus.out_last), 0);
                return;
            end
            tick();
        end
        chk({tag, "_timeout"}, 32'(budget), 0);
    endtask

    initial begin
        Rst           = 1'b1;
        start         = 1'b1;
        num_rows      = 16'd5;
        last_sel      = 2'd1;
        bus.out_ready = 1'b1;

        // 1: reset held 3 cycles with start asserted has no effect
        repeat (3) tick();
        chk_idle("rst_hold");
        Rst   = 1'b0;
        start = 1'b0;
        tick();
        chk_idle("rst_release");

        // 2: 3 rows x 3 sels, ready always high
        push_sweep(3, 2);
        do_start(3, 2);
        run("full", 32'h0, 0, -1, 40);
        tick();
        chk_idle("full_idle");

        // 3: stalls with ready pattern 1,0,0,1,0,1,1
        push_sweep(2, 1);
        do_start(2, 1);
        run("stall", 32'b1101001, 7, -1, 40);
        tick();
        chk_idle("stall_idle");

        // 4: edge configurations
        push_sweep(1, 0);
        do_start(1, 0);
        run("single", 32'h0, 0, -1, 10);
        tick();
        do_start(0, 2);
        run("zero_rows", 32'h0, 0, -1, 10);
        tick();
        chk_idle("zero_idle");
        push_sweep(2, 3);
        do_start(2, 3);
        run("sat_sel", 32'h0, 0, -1, 20);
        tick();

        // 5a: start re-asserted with a new num_rows mid-sweep is ignored, including in DONE
        push_sweep(4, 2);
        do_start(4, 2);
        start    = 1'b1;
        num_rows = 16'd1;
        last_sel = 2'd0;
        run("restart_ign", 32'b0110, 4, -1, 60);
        start = 1'b0;
        tick();
        chk_idle("restart_idle");

        // 5b: reset after beat 5 abandons the sweep without done
        push_sweep(4, 2);
        do_start(4, 2);
        run("pre_rst", 32'h0, 0, 5, 20);
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        chk_idle("mid_rst");
        sb.delete();
        tick();
        chk_idle("mid_rst_nodone");
        push_sweep(4, 2);
        do_start(4, 2);
        run("post_rst", 32'h0, 0, -1, 40);

        // 6: back-to-back, start in the IDLE cycle after done
        tick();
        push_sweep(2, 0);
        do_start(2, 0);
        run("b2b", 32'h0, 0, -1, 10);
        tick();
        chk_idle("end_idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gen_window_sequencer.md
Name: gen_window_sequencer

Overview:
Sequencer for the generate_window multiply stage. It walks frame rows and, for each row, steps the window-column select through 0..last_sel. Each step issues a frow / check_wcol_out pair to the four-lane multiplier stage over a valid/ready handshake. It sits between the vbsme control unit, which supplies start and dimensions, and the multiplier stage; it pulses done when the full sweep has been accepted.

Parameters:
ROW_W, 16, width of the row counter and of num_rows; maximum sweep is 2^ROW_W-1 rows.

Ports:
Clk  input  1  system clock; all state changes on rising edge.
Rst  input  1  synchronous, active-high reset.
start  input  1  one-cycle request to begin a sweep; sampled only in IDLE.
num_rows  input  ROW_W  number of frame rows to sweep; latched on accepted start.
last_sel  input  2  highest window-column select per row (0..2); latched on accepted start.
out_ready  input  1  downstream multiplier stage can accept the current beat.
out_valid  output  1  frow/check_wcol_out/out_last hold a valid beat.
frow  output  32  current frame row index, zero-extended from ROW_W bits.
check_wcol_out  output  2  current window-column select (0..2) driving the constant muxes.
out_last  output  1  current beat is the final beat of the sweep.
busy  output  1  high while in ISSUE.
done  output  1  one-cycle pulse after the final beat transfers.

Behaviour:
- Reset:
  - Rst=1 at a clock edge forces state IDLE and clears row and sel counters and both latched configuration registers.
  - All outputs go to 0: out_valid, frow, check_wcol_out, out_last, busy, done.
  - Reset mid-sweep abandons the sweep; no done is issued.
- States: IDLE, ISSUE, DONE, held in a registered FSM.
- IDLE:
  - out_valid=0, busy=0, done=0.
  - start=1 with num_rows!=0: latch num_rows and last_sel into cfg_rows and cfg_sel, set row=0 and sel=0, and go to ISSUE.
  - Latency start->out_valid is 1 cycle.
  - last_sel=3 is latched as 2 (saturate).
  - start=1 with num_rows==0: go to DONE directly; no beats are issued.
- ISSUE:
  - out_valid=1, busy=1.
  - frow = {zeros, row}; check_wcol_out = sel.
  - out_last = (row==cfg_rows-1) && (sel==cfg_sel), decoded combinationally from registered counters.
  - A transfer occurs in a cycle with out_valid && out_ready.
  - Transfer with sel<cfg_sel: sel++.
  - Transfer with sel==cfg_sel and not last: sel=0, row++.
  - Transfer of the last beat: go to DONE; counters hold.
  - out_ready=0: all outputs and counters hold unchanged, with no limit on stall length.
  - start is ignored in ISSUE; num_rows and last_sel changes are ignored once latched.
- DONE:
  - One cycle: done=1, out_valid=0, busy=0, out_last=0; next state IDLE.
  - start in DONE is ignored; a new start is accepted in the IDLE cycle that follows.
- Output rules:
  - All outputs are registered or derived from registered state only; no combinational path from out_ready to out_valid.
- Arithmetic:
  - Total beats = cfg_rows*(cfg_sel+1).
  - The row counter never wraps, because the sweep ends at cfg_rows-1.
  - num_rows = 2^ROW_W-1 is legal.
- Minimum sweep (num_rows=1, last_sel=0): one beat, which carries out_last=1.
- Back-to-back sweeps: minimum gap from done to the next out_valid is 2 cycles (DONE, IDLE accepting start, then ISSUE).

Test Plan:
1. Rst held 3 cycles, then released -> all outputs 0 and state IDLE; start pulse while Rst=1 has no effect.
2. start with num_rows=3, last_sel=2, out_ready=1 constantly -> out_valid rises 1 cycle after start.
   - 9 consecutive beats are issued.
   - (frow,sel) sequence: (0,0)(0,1)(0,2)(1,0)(1,1)(1,2)(2,0)(2,1)(2,2).
   - out_last=1 only on (2,2); done pulses the cycle after, then IDLE.
3. num_rows=2, last_sel=1; out_ready toggles 1,0,0,1,0,1,1 -> beats (0,0)(0,1)(1,0)(1,1).
   - Outputs are stable during every ready=0 cycle.
   - No beat is duplicated or skipped; done follows the 4th transfer.
4. Edge configurations:
   - num_rows=1, last_sel=0 -> single beat frow=0, sel=0, out_last=1, then done.
   - num_rows=0 -> no out_valid; done pulses 1 cycle after start.
   - last_sel=3 -> behaves as last_sel=2 (3 beats per row).
5. Mid-sweep disturbances, with num_rows=4, last_sel=2:
   - start re-asserted during ISSUE and num_rows changed to 1 -> sweep continues with the original 12 beats.
   - Rst asserted after beat 5 -> next cycle all outputs 0 and IDLE, no done; a fresh start restarts at frow=0, sel=0.
6. Back-to-back sweeps: start again in the IDLE cycle after done -> the second sweep's first beat appears exactly 1 cycle after that start.
